// File: rtl/state_sequencer.sv
// Cyclic phase/slot sequencer: steps a state index through NUM_STATES states with a programmable dwell, in wrap/saturate/ping-pong modes.
// Latency: every output is registered; a decision taken at clock edge k is visible just after edge k.
// Backpressure: none; enable=0 freezes all state, and load overrides enable.
//
// Ports:
//   clock, reset_n        - rising-edge clock; synchronous active-low reset (highest priority)
//   enable, dir, mode     - advance gate; 0=up/1=down; 0=wrap 1=saturate 2=ping-pong 3=wrap
//   load, load_value      - synchronous load of a (clamped) state index
//   dwell                 - each state lasts dwell+1 enabled cycles
//   state                 - current state index
//   step_pulse/wrap_pulse - one-cycle event pulses
//   done                  - saturate mode is parked at the end state for dir
module state_sequencer #(
    parameter int  NUM_STATES = 4,
    parameter int  DWELL_W    = 8,
    localparam int SW         = $clog2(NUM_STATES)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               dir,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [SW-1:0]      load_value,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SW-1:0]      state,
    output logic               step_pulse,
    output logic               wrap_pulse,
    output logic               done
);

    localparam logic [SW-1:0] LAST      = SW'(NUM_STATES - 1);
    localparam logic [1:0]    MODE_SAT  = 2'd1;
    localparam logic [1:0]    MODE_PING = 2'd2;

    logic [SW-1:0]      state_q, state_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               bounce_q, bounce_d;
    logic               step_pulse_q, step_pulse_d;
    logic               wrap_pulse_q, wrap_pulse_d;
    logic               done_q, done_d;

    logic               eff_dir;
    logic               at_top, at_bot;
    logic               eff_at_end;
    logic               dir_at_end;
    logic [SW-1:0]      dir_end;
    logic [SW-1:0]      state_inc, state_dec;

    // bounce reflects the ping-pong reversal; wrap mode also follows eff_dir
    assign eff_dir    = dir ^ bounce_q;
    assign at_top     = (state_q == LAST);
    assign at_bot     = (state_q == '0);
    assign eff_at_end = eff_dir ? at_bot : at_top;
    assign dir_at_end = dir ? at_bot : at_top;
    assign dir_end    = dir ? '0 : LAST;
    assign state_inc  = state_q + SW'(1);
    assign state_dec  = state_q - SW'(1);

    always_comb begin
        state_d      = state_q;
        dwell_cnt_d  = dwell_cnt_q;
        bounce_d     = bounce_q;
        step_pulse_d = 1'b0;
        wrap_pulse_d = 1'b0;
        done_d       = done_q;

        if (load) begin
            state_d     = (load_value > LAST) ? LAST : load_value;
            dwell_cnt_d = '0;
            bounce_d    = 1'b0;
            done_d      = (mode == MODE_SAT) && (state_d == dir_end);
        end else if (enable) begin
            // leaving ping-pong discards any pending reversal
            if (mode != MODE_PING) begin
                bounce_d = 1'b0;
            end
            // >= rather than == so a dwell lowered mid-count still terminates
            if (dwell_cnt_q < dwell) begin
                dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
            end else begin
                dwell_cnt_d = '0;
                case (mode)
                    MODE_SAT: begin
                        if (!dir_at_end) begin
                            state_d      = dir ? state_dec : state_inc;
                            step_pulse_d = 1'b1;
                        end
                    end
                    MODE_PING: begin
                        step_pulse_d = 1'b1;
                        if (eff_at_end) begin
                            bounce_d     = ~bounce_q;
                            state_d      = eff_dir ? state_inc : state_dec;
                            wrap_pulse_d = 1'b1;
                        end else begin
                            state_d = eff_dir ? state_dec : state_inc;
                        end
                    end
                    default: begin
                        step_pulse_d = 1'b1;
                        if (eff_at_end) begin
                            // explicit wrap: NUM_STATES need not be a power of two
                            state_d      = eff_dir ? LAST : '0;
                            wrap_pulse_d = 1'b1;
                        end else begin
                            state_d = eff_dir ? state_dec : state_inc;
                        end
                    end
                endcase
            end
            done_d = (mode == MODE_SAT) && (state_d == dir_end);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= '0;
            dwell_cnt_q  <= '0;
            bounce_q     <= 1'b0;
            step_pulse_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_cnt_q  <= dwell_cnt_d;
            bounce_q     <= bounce_d;
            step_pulse_q <= step_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            done_q       <= done_d;
        end
    end

    assign state      = state_q;
    assign step_pulse = step_pulse_q;
    assign wrap_pulse = wrap_pulse_q;
    assign done       = done_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Testbench for state_sequencer: two instances (4 and 5 states) share one stimulus stream.
// Latency: expectations are queued before each edge and compared 1 time unit after it.
// Backpressure: none; the bench drives every cycle.
module tb_state_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       load = 1'b0;
    logic [1:0] lv4 = 2'd0;
    logic [2:0] lv5 = 3'd0;
    logic [7:0] dwell = 8'd0;

    logic [1:0] s4;
    logic [2:0] s5;
    logic       sp4, wp4, dn4, sp5, wp5, dn5;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    state_sequencer #(.NUM_STATES(4), .DWELL_W(8)) u4 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .dir(dir), .mode(mode),
        .load(load), .load_value(lv4), .dwell(dwell),
        .state(s4), .step_pulse(sp4), .wrap_pulse(wp4), .done(dn4)
    );

    state_sequencer #(.NUM_STATES(5), .DWELL_W(8)) u5 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .dir(dir), .mode(mode),
        .load(load), .load_value(lv5), .dwell(dwell),
        .state(s5), .step_pulse(sp5), .wrap_pulse(wp5), .done(dn5)
    );

    typedef struct packed {
        int st; int cnt; int bnc; int sp; int wp; int dn;
    } mdl_t;

    typedef struct packed {
        int inst; int st; int sp; int wp; int dn;
    } exp_t;

    mdl_t m4 = '{default: 0};
    mdl_t m5 = '{default: 0};
    exp_t exp_q[$];

    // Reference behaviour using signed integer stepping and range tests.
    function automatic mdl_t mstep(mdl_t m, int n, int lv);
        mdl_t r;
        int   ed, dlt, nx;
        r    = m;
        r.sp = 0;
        r.wp = 0;
        if (!reset_n) begin
            r = '{default: 0};
            return r;
        end
        if (load) begin
            r.st  = (lv > n - 1) ? n - 1 : lv;
            r.cnt = 0;
            r.bnc = 0;
            r.dn  = (mode == 2'd1 && r.st == (dir ? 0 : n - 1)) ? 1 : 0;
            return r;
        end
        if (!enable) return r;
        ed = int'(dir) ^ m.bnc;
        if (mode != 2'd2) r.bnc = 0;
        if (m.cnt < int'(dwell)) begin
            r.cnt = m.cnt + 1;
        end else begin
            r.cnt = 0;
            if (mode == 2'd1) begin
                nx = m.st + (dir ? -1 : 1);
                if (nx >= 0 && nx < n) begin
                    r.st = nx;
                    r.sp = 1;
                end
            end else begin
                dlt  = ed ? -1 : 1;
                nx   = m.st + dlt;
                r.sp = 1;
                if (nx >= 0 && nx < n) begin
                    r.st = nx;
                end else if (mode == 2'd2) begin
                    r.bnc = 1 - m.bnc;
                    r.st  = m.st - dlt;
                    r.wp  = 1;
                end else begin
                    r.st = (nx + n) % n;
                    r.wp = 1;
                end
            end
        end
        r.dn = (mode == 2'd1 && r.st == (dir ? 0 : n - 1)) ? 1 : 0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: push model expectations, take the edge, pop and compare.
    task automatic cyc();
        exp_t e;
        m4 = mstep(m4, 4, int'(lv4));
        m5 = mstep(m5, 5, int'(lv5));
        exp_q.push_back('{inst: 0, st: m4.st, sp: m4.sp, wp: m4.wp, dn: m4.dn});
        exp_q.push_back('{inst: 1, st: m5.st, sp: m5.sp, wp: m5.wp, dn: m5.dn});
        @(posedge clock);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.inst == 0) begin
                chk("sb4_state", 32'(s4), e.st);
                chk("sb4_step",  32'(sp4), e.sp);
                chk("sb4_wrap",  32'(wp4), e.wp);
                chk("sb4_done",  32'(dn4), e.dn);
            end else begin
                chk("sb5_state", 32'(s5), e.st);
                chk("sb5_step",  32'(sp5), e.sp);
                chk("sb5_wrap",  32'(wp5), e.wp);
                chk("sb5_done",  32'(dn5), e.dn);
            end
        end
    endtask

    int base_seq[6] = '{1, 2, 3, 0, 1, 2};
    int dwl_seq[6]  = '{0, 0, 1, 1, 1, 2};
    int sat_seq[4]  = '{1, 0, 0, 0};
    int png_seq[8]  = '{1, 2, 3, 2, 1, 0, 1, 2};

    initial begin
        // reset
        reset_n = 1'b0;
        cyc();
        cyc();
        chk("rst_state", 32'(s4), 0);
        chk("rst_pulses", {29'd0, sp4, wp4, dn4}, 0);

        // baseline 4-state wrap cycle
        reset_n = 1'b1; enable = 1'b1; mode = 2'd0; dir = 1'b0; dwell = 8'd0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("base_state", 32'(s4), base_seq[i]);
            chk("base_step", 32'(sp4), 1);
            chk("base_wrap", 32'(wp4), (base_seq[i] == 0) ? 1 : 0);
        end

        // dwell of 2: each state held three cycles
        dwell = 8'd2; load = 1'b1; lv4 = 2'd0; lv5 = 3'd0;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("dwell_state", 32'(s4), dwl_seq[i]);
        end
        // freeze mid-dwell, then finish the remaining dwell
        load = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("freeze_state", 32'(s4), 0);
            chk("freeze_step", 32'(sp4), 0);
        end
        enable = 1'b1;
        cyc();
        chk("resume_hold", 32'(s4), 0);
        cyc();
        chk("resume_adv", 32'(s4), 1);
        chk("resume_step", 32'(sp4), 1);

        // saturate down on 5 states from 2
        dwell = 8'd0; mode = 2'd1; dir = 1'b1; load = 1'b1; lv5 = 3'd2; lv4 = 2'd2;
        cyc();
        chk("sat_load", 32'(s5), 2);
        chk("sat_load_done", 32'(dn5), 0);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("sat_state", 32'(s5), sat_seq[i]);
            chk("sat_done", 32'(dn5), (sat_seq[i] == 0) ? 1 : 0);
            chk("sat_step", 32'(sp5), (i < 2) ? 1 : 0);
        end
        dir = 1'b0;
        cyc();
        chk("sat_rev_state", 32'(s5), 1);
        chk("sat_rev_done", 32'(dn5), 0);

        // ping-pong on 4 states
        mode = 2'd2; dir = 1'b0; load = 1'b1; lv4 = 2'd0; lv5 = 3'd0;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("png_state", 32'(s4), png_seq[i]);
            chk("png_wrap", 32'(wp4), (i == 3 || i == 6) ? 1 : 0);
            chk("png_step", 32'(sp4), 1);
        end

        // load beats enable, out-of-range value clamps
        mode = 2'd0; enable = 1'b1; load = 1'b1; lv5 = 3'd7; lv4 = 2'd3;
        cyc();
        chk("clamp_state", 32'(s5), 4);
        chk("clamp_pulses", {30'd0, sp5, wp5}, 0);
        // reset beats load
        reset_n = 1'b0;
        cyc();
        chk("rst_load_state", 32'(s5), 0);
        chk("rst_load_outs", {29'd0, sp5, wp5, dn5}, 0);

        // constrained-random soak, scoreboard only
        reset_n = 1'b1; load = 1'b0;
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            load    = ($urandom_range(0, 11) == 0);
            enable  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) dwell = 8'($urandom_range(0, 3));
            lv4 = 2'($urandom_range(0, 3));
            lv5 = 3'($urandom_range(0, 7));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
